vector_mem_sequencer: RTL and testbench
=======================================

Name: vector_mem_sequencer

Overview:
- Initiator side of the data-memory interface. Drives the address/data/write-enable/byte-mode port of the data memory manager on behalf of the vector datapath.
- Converts one vector load or store request (LANES elements at consecutive element addresses) into a sequence of single-element memory accesses.
- Loads: waits out the memory read latency for each element, assembles the result vector and returns it with a one-cycle done pulse.

Parameters:
LANES, 4, number of vector elements per request (>=1)
DATA_W, 32, element and memory data width
ADDR_W, 32, memory address width
READ_LAT, 2, clock edges from a stable mem_address_o until mem_data_i is valid

Ports:
CLK  input  1  system clock, rising edge
reset_n_i  input  1  synchronous, active-low reset
start_i  input  1  request strobe; accepted only when busy_o=0
store_i  input  1  1=store, 0=load; sampled on accept
byte_mode_i  input  1  1=byte elements, 0=word elements; sampled on accept
base_addr_i  input  ADDR_W  address of lane 0; sampled on accept
vec_data_i  input  LANES*DATA_W  store data, lane 0 in LSBs; sampled on accept
busy_o  output  1  high in every non-IDLE state
done_o  output  1  one-cycle completion pulse
vec_data_o  output  LANES*DATA_W  last load result, lane 0 in LSBs
mem_address_o  output  ADDR_W  memory address
mem_data_o  output  DATA_W  memory write data
mem_wren_o  output  1  memory write enable
mem_byte_mode_o  output  1  memory byte mode
mem_data_i  input  DATA_W  memory read data

Behaviour:
- Reset (reset_n_i=0 at a rising edge): state IDLE, all outputs 0, vec_data_o=0, lane index and wait counter 0.
- Reset has priority over everything. Mid-operation reset aborts: no done_o, mem_wren_o=0 from the next cycle, partial load data discarded.
- States: IDLE, STORE, LOAD, DONE.
- IDLE: mem_* outputs 0.
  - start_i=1 at an edge latches store_i, byte_mode_i, base_addr_i, vec_data_i.
  - Goes to STORE or LOAD; lane index k=0.
  - start_i while busy_o=1 is ignored (not queued).
- Addressing: element k uses mem_address_o = base + k, modulo 2^ADDR_W (wrap-around, no error). Stride is 1 in both modes.
- mem_byte_mode_o = latched byte mode during STORE and LOAD.
- STORE:
  - One element per cycle; mem_wren_o=1.
  - mem_data_o = lane k; in byte mode, only bits [7:0] are kept and the rest zeroed.
  - After lane LANES-1, go to DONE.
  - mem_wren_o is high for exactly LANES consecutive cycles.
- LOAD:
  - mem_wren_o=0, mem_data_o=0.
  - Address k is held stable for READ_LAT+1 cycles; wait counter runs 0..READ_LAT.
  - At the edge where counter==READ_LAT, capture mem_data_i into shadow lane k; in byte mode, zero-extend [7:0].
  - Then k+1 and counter=0. After lane LANES-1 is captured, go to DONE.
- DONE (one cycle):
  - done_o=1, busy_o=1, mem_* outputs 0.
  - On load, vec_data_o is updated from the shadow register at the edge entering DONE, i.e. all lanes change together.
  - Store leaves vec_data_o unchanged. vec_data_o holds until the next load completes.
  - Next state IDLE. start_i is accepted again from IDLE only, so the earliest restart is one cycle after done_o.
- Latency, counting the accept edge as cycle 0:
  - Store: done_o in cycle LANES+1.
  - Load: done_o in cycle LANES*(READ_LAT+1)+1. With defaults: store=5, load=13.

Test Plan:
- Reset → busy_o=0, done_o=0, mem_wren_o=0, mem_address_o=0, vec_data_o=0; reset held with start_i=1 → stays IDLE.
- Word store, base 0x10000, lanes 0xA0,0xA1,0xA2,0xA3 → mem_wren_o=1 cycles 1-4 with address/data 0x10000/0xA0 … 0x10003/0xA3, done_o in cycle 5.
- Word load from 0x10000 against a behavioural memory (READ_LAT=2) preloaded as above → each address held 3 cycles, done_o in cycle 13, vec_data_o=0x000000A3_000000A2_000000A1_000000A0.
- Byte load, base 0x20000, memory word 0x12345678 at each address → every lane 0x00000078, mem_byte_mode_o=1 during LOAD.
- Wrap: store with base 0xFFFFFFFE → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- start_i pulsed during busy → ignored, single done_o. reset_n_i=0 in cycle 6 of a load → mem_wren_o=0, no done_o, vec_data_o=0, IDLE next cycle.

Source files
------------

// File: rtl/vector_mem_sequencer.sv
// Vector load/store sequencer: turns one LANES-element request
// into single-element data-memory accesses.
module vector_mem_sequencer #(
  parameter int LANES    = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int READ_LAT = 2
) (
  input  logic                      CLK,
  input  logic                      reset_n_i,
  input  logic                      start_i,
  input  logic                      store_i,
  input  logic                      byte_mode_i,
  input  logic [ADDR_W-1:0]         base_addr_i,
  input  logic [LANES*DATA_W-1:0]   vec_data_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [LANES*DATA_W-1:0]   vec_data_o,
  output logic [ADDR_W-1:0]         mem_address_o,
  output logic [DATA_W-1:0]         mem_data_o,
  output logic                      mem_wren_o,
  output logic                      mem_byte_mode_o,
  input  logic [DATA_W-1:0]         mem_data_i
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    STORE,
    LOAD,
    DONE
  } state_t;

  state_t                    state;
  state_t                    state_n;
  logic [LW-1:0]             lane;
  logic [CW-1:0]             cnt;
  logic                      byte_q;
  logic [ADDR_W-1:0]         base_q;
  logic [LANES*DATA_W-1:0]   wdata_q;
  logic [LANES*DATA_W-1:0]   shadow;
  logic [LANES*DATA_W-1:0]   shadow_n;
  logic [LANES*DATA_W-1:0]   vec_q;
  logic                      last_lane;
  logic                      cnt_hit;
  logic [DATA_W-1:0]         lane_wdata;
  logic [DATA_W-1:0]         rd_elem;

  assign last_lane  = lane == LW'(LANES - 1);
  assign cnt_hit    = cnt == CW'(READ_LAT);
  assign lane_wdata = wdata_q[lane*DATA_W +: DATA_W];
  assign rd_elem    = byte_q ? DATA_W'(mem_data_i[7:0])
                             : mem_data_i;
  assign vec_data_o = vec_q;

  // Next state, memory port drive and shadow-lane merge
  always_comb begin
    state_n         = state;
    busy_o          = state != IDLE;
    done_o          = 1'b0;
    mem_address_o   = '0;
    mem_data_o      = '0;
    mem_wren_o      = 1'b0;
    mem_byte_mode_o = 1'b0;
    shadow_n        = shadow;
    unique case (state)
      IDLE: begin
        if (start_i)
          state_n = store_i ? STORE : LOAD;
      end
      STORE: begin
        mem_address_o   = base_q + ADDR_W'(lane);
        mem_wren_o      = 1'b1;
        mem_byte_mode_o = byte_q;
        mem_data_o      = byte_q
                        ? DATA_W'(lane_wdata[7:0])
                        : lane_wdata;
        if (last_lane)
          state_n = DONE;
      end
      LOAD: begin
        mem_address_o   = base_q + ADDR_W'(lane);
        mem_byte_mode_o = byte_q;
        if (cnt_hit) begin
          shadow_n[lane*DATA_W +: DATA_W] = rd_elem;
          if (last_lane)
            state_n = DONE;
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, request latch, lane/wait counters and result registers
  always_ff @(posedge CLK) begin
    if (!reset_n_i) begin
      state   <= IDLE;
      lane    <= '0;
      cnt     <= '0;
      byte_q  <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      shadow  <= '0;
      vec_q   <= '0;
    end else begin
      state  <= state_n;
      shadow <= shadow_n;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            byte_q  <= byte_mode_i;
            base_q  <= base_addr_i;
            wdata_q <= vec_data_i;
            lane    <= '0;
            cnt     <= '0;
          end
        end
        STORE: begin
          lane <= last_lane ? '0 : lane + 1'b1;
        end
        LOAD: begin
          if (cnt_hit) begin
            cnt  <= '0;
            lane <= last_lane ? '0 : lane + 1'b1;
            if (last_lane)
              vec_q <= shadow_n;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Scoreboard bench for vector_mem_sequencer with a
// two-stage-latency behavioural data memory.
module tb_vector_mem_sequencer;

  localparam int LANES = 4;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int VW    = LANES * DW;

  logic          CLK = 1'b0;
  logic          reset_n_i;
  logic          start_i;
  logic          store_i;
  logic          byte_mode_i;
  logic [AW-1:0] base_addr_i;
  logic [VW-1:0] vec_data_i;
  logic          busy_o;
  logic          done_o;
  logic [VW-1:0] vec_data_o;
  logic [AW-1:0] mem_address_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_wren_o;
  logic          mem_byte_mode_o;
  logic [DW-1:0] mem_data_i;

  vector_mem_sequencer #(
    .LANES(LANES), .DATA_W(DW), .ADDR_W(AW), .READ_LAT(2)
  ) dut (
    .CLK(CLK),
    .reset_n_i(reset_n_i),
    .start_i(start_i),
    .store_i(store_i),
    .byte_mode_i(byte_mode_i),
    .base_addr_i(base_addr_i),
    .vec_data_i(vec_data_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .vec_data_o(vec_data_o),
    .mem_address_o(mem_address_o),
    .mem_data_o(mem_data_o),
    .mem_wren_o(mem_wren_o),
    .mem_byte_mode_o(mem_byte_mode_o),
    .mem_data_i(mem_data_i)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          bm;
  } acc_t;

  typedef struct {
    int            cyc;
    logic [VW-1:0] vec;
  } done_t;

  acc_t  wq[$];
  acc_t  rq[$];
  done_t dq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit mon_en = 1'b0;
  logic [VW-1:0] last_vec = '0;

  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] d1 = '0;
  logic [DW-1:0] d2 = '0;

  assign mem_data_i = d2;

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : '0;
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory: data valid two edges after the address is stable
  always @(posedge CLK) begin
    d2 <= d1;
    d1 <= rd(mem_address_o);
    if (mem_wren_o)
      mem[mem_address_o] = mem_data_o;
  end

  task automatic chk(input string nm,
                     input logic [VW-1:0] act,
                     input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  // Monitor: pop and compare on every memory access and done pulse
  always @(negedge CLK) begin
    if (mon_en) begin
      if (mem_wren_o) begin
        if (wq.size() == 0) bad("unexpected_write");
        else begin
          acc_t w;
          w = wq.pop_front();
          chk("st_addr", VW'(mem_address_o), VW'(w.addr));
          chk("st_data", VW'(mem_data_o), VW'(w.data));
          chk("st_bm", VW'(mem_byte_mode_o), VW'(w.bm));
        end
      end else if (busy_o && !done_o) begin
        if (rq.size() == 0) bad("unexpected_read");
        else begin
          acc_t r;
          r = rq.pop_front();
          chk("ld_addr", VW'(mem_address_o), VW'(r.addr));
          chk("ld_bm", VW'(mem_byte_mode_o), VW'(r.bm));
          chk("ld_wdata", VW'(mem_data_o), '0);
        end
      end
      if (done_o) begin
        done_cnt++;
        if (dq.size() == 0) bad("unexpected_done");
        else begin
          done_t d;
          d = dq.pop_front();
          chk("done_cyc", VW'(cyc), VW'(d.cyc));
          chk("vec_out", vec_data_o, d.vec);
        end
      end
    end
  end

  task automatic do_req(input bit st, input bit bm,
                        input logic [AW-1:0] base,
                        input logic [VW-1:0] vec,
                        input logic [VW-1:0] exp_vec,
                        input bit pulse);
    int n;
    done_t d;
    @(negedge CLK);
    start_i     = 1'b1;
    store_i     = st;
    byte_mode_i = bm;
    base_addr_i = base;
    vec_data_i  = vec;
    n = cyc;
    for (int k = 0; k < LANES; k++) begin
      acc_t a;
      a.addr = base + AW'(k);
      a.bm   = bm;
      a.data = vec[k*DW +: DW];
      if (bm) a.data = a.data & 32'hFF;
      if (st) wq.push_back(a);
      else begin
        a.data = '0;
        repeat (3) rq.push_back(a);
      end
    end
    d.cyc = st ? n + LANES + 1 : n + LANES * 3 + 1;
    d.vec = st ? last_vec : exp_vec;
    if (!st) last_vec = exp_vec;
    dq.push_back(d);
    @(negedge CLK);
    start_i     = 1'b0;
    store_i     = ~st;
    base_addr_i = 32'hDEAD0000;
    vec_data_i  = '1;
    if (pulse) begin
      repeat (2) @(negedge CLK);
      start_i     = 1'b1;
      store_i     = 1'b1;
      base_addr_i = 32'h50000;
      @(negedge CLK);
      start_i = 1'b0;
    end
    for (int i = 0; i < 60 && busy_o; i++) @(negedge CLK);
    if (busy_o) bad("req_timeout");
  endtask

  initial begin
    int n;
    int saved;
    reset_n_i   = 1'b0;
    start_i     = 1'b1;
    store_i     = 1'b1;
    byte_mode_i = 1'b0;
    base_addr_i = 32'h1234;
    vec_data_i  = '1;
    repeat (2) @(posedge CLK);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("reset_ctl",
          VW'({busy_o, done_o, mem_wren_o}), '0);
      chk("reset_addr", VW'(mem_address_o), '0);
      chk("reset_vec", vec_data_o, '0);
    end
    start_i   = 1'b0;
    reset_n_i = 1'b1;
    mon_en    = 1'b1;
    @(negedge CLK);

    do_req(1, 0, 32'h10000,
           {32'hA3, 32'hA2, 32'hA1, 32'hA0}, '0, 0);
    do_req(0, 0, 32'h10000, '0,
           {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1);
    do_req(1, 0, 32'h20000, {4{32'h12345678}}, '0, 0);
    do_req(0, 1, 32'h20000, '0, {4{32'h00000078}}, 0);
    do_req(1, 1, 32'h30000,
           {32'hEEFF0011, 32'hAABBCCDD,
            32'h55667788, 32'h11223344}, '0, 0);
    do_req(0, 0, 32'h30000, '0,
           {32'h11, 32'hDD, 32'h88, 32'h44}, 0);
    do_req(1, 0, 32'hFFFFFFFE,
           {32'h4, 32'h3, 32'h2, 32'h1}, '0, 0);

    // Abort a load with reset during its sixth cycle
    saved = done_cnt;
    @(negedge CLK);
    start_i     = 1'b1;
    store_i     = 1'b0;
    byte_mode_i = 1'b0;
    base_addr_i = 32'h10000;
    n = cyc;
    for (int k = 0; k < 2; k++) begin
      acc_t a;
      a.addr = 32'h10000 + AW'(k);
      a.data = '0;
      a.bm   = 1'b0;
      repeat (3) rq.push_back(a);
    end
    @(negedge CLK);
    start_i = 1'b0;
    while (cyc < n + 6) @(negedge CLK);
    reset_n_i = 1'b0;
    @(negedge CLK);
    chk("abort_busy", VW'(busy_o), '0);
    chk("abort_wren", VW'(mem_wren_o), '0);
    chk("abort_vec", vec_data_o, '0);
    reset_n_i = 1'b1;
    repeat (20) @(negedge CLK);
    chk("abort_no_done", VW'(done_cnt), VW'(saved));

    for (int i = 0; i < 200 && (wq.size() + rq.size()
         + dq.size()) != 0; i++) @(negedge CLK);
    chk("wq_empty", VW'(wq.size()), '0);
    chk("rq_empty", VW'(rq.size()), '0);
    chk("dq_empty", VW'(dq.size()), '0);
    chk("done_total", VW'(done_cnt), VW'(7));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
